draw_layer_arbiter: RTL and testbench

- Shares the single VGA RGB output among NUM_LAYERS bitmap drawers (hook, rope, gold/stone objects, miner, background-overlay) by fixed priority; index 0 is highest priority and is the collider (hook).
- Latches the first pixel-level collision per frame between layer 0 and any other enabled layer, together with its hit-edge code, and reports it once at the next startOfFrame.
- Sits between the per-object bitmap blocks (which present registered drawingRequest/RGB/HitEdgeCode) and the VGA controller and game-logic FSM.

---
 rtl/gold_miner_vga_pkg.sv | 18 +
 rtl/draw_layer_arbiter_if.sv | 30 +++
 rtl/priority_encoder_n.sv | 24 ++
 rtl/draw_layer_arbiter.sv | 125 ++++++++++++
 tb/tb_draw_layer_arbiter.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/gold_miner_vga_pkg.sv
// Shared definitions for the VGA drawing path: colour constants, hit-edge
// codes and the collision-latch state encoding.
package gold_miner_vga_pkg;

  localparam logic [7:0] TRANSPARENT_ENCODING   = 8'hFF;
  localparam logic [7:0] BACKGROUND_RGB_DEFAULT = 8'h00;

  // Which side of the collider bitmap was touched.
  typedef logic [2:0] hit_edge_t;
  localparam hit_edge_t EDGE_NONE   = 3'd0;
  localparam hit_edge_t EDGE_LEFT   = 3'd1;
  localparam hit_edge_t EDGE_TOP    = 3'd2;
  localparam hit_edge_t EDGE_RIGHT  = 3'd3;
  localparam hit_edge_t EDGE_BOTTOM = 3'd4;

  typedef enum logic {ARMED, LATCHED} arb_state_t;

endpackage

// File: rtl/draw_layer_arbiter_if.sv
// Bundle between the bitmap drawers / game logic (master) and the
// layer arbiter (slave).
interface draw_layer_arbiter_if #(
  parameter int NUM_LAYERS  = 4,
  parameter int COUNT_WIDTH = 8
);
  import gold_miner_vga_pkg::*;

  logic                              startOfFrame;
  logic [NUM_LAYERS-1:0]             drawRequest;
  logic [NUM_LAYERS-1:0][7:0]        layerRGB;
  hit_edge_t                         hookHitEdge;
  logic [NUM_LAYERS-1:0]             layerEnableCfg;
  logic [7:0]                        RGBOut;
  logic                              collision;
  logic [NUM_LAYERS-2:0]             collisionMask;
  hit_edge_t                         collisionEdge;
  logic [COUNT_WIDTH-1:0]            collisionCount;

  modport master (
    output startOfFrame, drawRequest, layerRGB, hookHitEdge, layerEnableCfg,
    input  RGBOut, collision, collisionMask, collisionEdge, collisionCount
  );

  modport slave (
    input  startOfFrame, drawRequest, layerRGB, hookHitEdge, layerEnableCfg,
    output RGBOut, collision, collisionMask, collisionEdge, collisionCount
  );

endinterface

// File: rtl/priority_encoder_n.sv
// Lowest-set-index encoder: index 0 wins. any is low when nothing requests,
// in which case idx is 0 and must be ignored.
module priority_encoder_n #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int IW = $clog2(N);

  // Scan from the top down so the lowest requesting index is the last write.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_layer_arbiter.sv
// Fixed-priority mux of the bitmap layers onto the VGA pixel, plus a
// per-frame collision latch between layer 0 (hook) and every other layer.
// A frame's collision summary is published on the cycle after the
// startOfFrame that closes it.
module draw_layer_arbiter
  import gold_miner_vga_pkg::*;
#(
  parameter int         NUM_LAYERS     = 4,
  parameter logic [7:0] BACKGROUND_RGB = BACKGROUND_RGB_DEFAULT,
  parameter int         COUNT_WIDTH    = 8
) (
  input logic                clk,
  input logic                resetN,
  draw_layer_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_LAYERS);

  logic [NUM_LAYERS-1:0]  shadow_q, shadow_now, eff;
  logic [NUM_LAYERS-2:0]  others;
  logic                   cp, rpt;
  logic [IW-1:0]          win_idx;
  logic                   win_any;

  arb_state_t             state_q, state_d;
  hit_edge_t              edge_q, edge_d;
  logic [NUM_LAYERS-2:0]  mask_q, mask_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [7:0]             rgb_q;
  logic                   coll_q;
  logic [NUM_LAYERS-2:0]  rmask_q;
  hit_edge_t              redge_q;
  logic [COUNT_WIDTH-1:0] rcnt_q;

  // A new enable mask takes effect on the startOfFrame cycle itself.
  assign shadow_now = bus.startOfFrame ? bus.layerEnableCfg : shadow_q;
  assign eff        = bus.drawRequest & shadow_now;
  assign others     = eff[NUM_LAYERS-1:1];
  assign cp         = eff[0] & (|others);
  assign rpt        = bus.startOfFrame & (state_q == LATCHED);

  priority_encoder_n #(.N(NUM_LAYERS)) u_penc (
    .req (eff),
    .idx (win_idx),
    .any (win_any)
  );

  // Enable shadow: only reloaded at frame boundaries to avoid tearing.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                shadow_q <= '1;
    else if (bus.startOfFrame)  shadow_q <= bus.layerEnableCfg;
  end

  // Registered pixel colour, one cycle behind the requests.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)      rgb_q <= BACKGROUND_RGB;
    else if (win_any) rgb_q <= bus.layerRGB[win_idx];
    else              rgb_q <= BACKGROUND_RGB;
  end

  // Collision FSM state and per-frame accumulators.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ARMED;
      edge_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a frame boundary clears first, then a collision pixel on
  // that same cycle seeds the new frame as its first hit.
  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    if (bus.startOfFrame) begin
      state_d = ARMED;
      edge_d  = '0;
      mask_d  = '0;
      cnt_d   = '0;
    end
    if (cp) begin
      if (bus.startOfFrame || state_q == ARMED) begin
        state_d = LATCHED;
        edge_d  = bus.hookHitEdge;
        mask_d  = others;
        cnt_d   = COUNT_WIDTH'(1);
      end else begin
        mask_d = mask_q | others;
        cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end
    end
  end

  // Report registers: pulse plus held summary of the closed frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      coll_q  <= 1'b0;
      rmask_q <= '0;
      redge_q <= '0;
      rcnt_q  <= '0;
    end else begin
      coll_q <= rpt;
      if (rpt) begin
        rmask_q <= mask_q;
        redge_q <= edge_q;
        rcnt_q  <= cnt_q;
      end
    end
  end

  assign bus.RGBOut         = rgb_q;
  assign bus.collision      = coll_q;
  assign bus.collisionMask  = rmask_q;
  assign bus.collisionEdge  = redge_q;
  assign bus.collisionCount = rcnt_q;

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// Directed bench for draw_layer_arbiter (4 layers, 8-bit counter).
module tb_draw_layer_arbiter;

  logic clk = 1'b0;
  logic resetN;
  int   n_asserts = 0;
  int   n_fail    = 0;

  always #5 clk = ~clk;

  draw_layer_arbiter_if #(.NUM_LAYERS(4), .COUNT_WIDTH(8)) bus ();

  draw_layer_arbiter #(
    .NUM_LAYERS     (4),
    .BACKGROUND_RGB (8'h00),
    .COUNT_WIDTH    (8)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_step();
    bus.startOfFrame = 1'b1;
    step();
    bus.startOfFrame = 1'b0;
  endtask

  initial begin
    resetN             = 1'b0;
    bus.startOfFrame   = 1'b0;
    bus.drawRequest    = '0;
    bus.hookHitEdge    = '0;
    bus.layerEnableCfg = 4'b1111;
    bus.layerRGB[0]    = 8'hA5;
    bus.layerRGB[1]    = 8'h1C;
    bus.layerRGB[2]    = 8'hE0;
    bus.layerRGB[3]    = 8'h33;
    step();
    step();

    // Reset state
    chk("rst_rgb",   32'(bus.RGBOut), 32'h00);
    chk("rst_coll",  32'(bus.collision), 32'h0);
    chk("rst_mask",  32'(bus.collisionMask), 32'h0);
    chk("rst_edge",  32'(bus.collisionEdge), 32'h0);
    chk("rst_count", 32'(bus.collisionCount), 32'h0);
    resetN = 1'b1;
    step();

    // Priority pick
    bus.drawRequest = 4'b0110; step();
    chk("prio_0110", 32'(bus.RGBOut), 32'h1C);
    bus.drawRequest = 4'b0000; step();
    chk("prio_none", 32'(bus.RGBOut), 32'h00);
    bus.drawRequest = 4'b1000; step();
    chk("prio_1000", 32'(bus.RGBOut), 32'h33);
    bus.drawRequest = 4'b0000;

    // Collision report
    sof_step();
    chk("arm_no_report", 32'(bus.collision), 32'h0);
    bus.drawRequest = 4'b0101; bus.hookHitEdge = 3'd2; step();
    chk("coll_rgb", 32'(bus.RGBOut), 32'hA5);
    bus.hookHitEdge = 3'd4; step();
    step();
    bus.drawRequest = 4'b0000; step();
    chk("coll_pre_sof", 32'(bus.collision), 32'h0);
    sof_step();
    chk("coll_pulse", 32'(bus.collision), 32'h1);
    chk("coll_mask",  32'(bus.collisionMask), 32'h2);
    chk("coll_edge",  32'(bus.collisionEdge), 32'h2);
    chk("coll_count", 32'(bus.collisionCount), 32'h3);
    step();
    chk("coll_single", 32'(bus.collision), 32'h0);
    chk("coll_hold",   32'(bus.collisionCount), 32'h3);

    // Enable shadowing: mid-frame change is ignored until the next frame
    bus.layerEnableCfg = 4'b1011;
    bus.drawRequest = 4'b0101; bus.hookHitEdge = 3'd5; step();
    chk("shadow_rgb_a", 32'(bus.RGBOut), 32'hA5);
    step();
    bus.drawRequest = 4'b0000;
    sof_step();
    chk("shadow_coll",  32'(bus.collision), 32'h1);
    chk("shadow_count", 32'(bus.collisionCount), 32'h2);
    chk("shadow_edge",  32'(bus.collisionEdge), 32'h5);
    bus.drawRequest = 4'b0101; step();
    chk("shadow_rgb_b", 32'(bus.RGBOut), 32'hA5);
    bus.drawRequest = 4'b0100; step();
    chk("shadow_disabled_rgb", 32'(bus.RGBOut), 32'h00);
    bus.drawRequest = 4'b0101; step();
    step();
    bus.drawRequest = 4'b0000;
    bus.layerEnableCfg = 4'b1111;
    sof_step();
    chk("shadow_no_coll",  32'(bus.collision), 32'h0);
    chk("shadow_hold_cnt", 32'(bus.collisionCount), 32'h2);

    // Boundary coincidence: cp on the startOfFrame cycle belongs to the new frame
    bus.drawRequest = 4'b0011; bus.hookHitEdge = 3'd6;
    sof_step();
    bus.drawRequest = 4'b0000;
    chk("coinc_no_pulse", 32'(bus.collision), 32'h0);
    step();
    sof_step();
    chk("coinc_pulse", 32'(bus.collision), 32'h1);
    chk("coinc_count", 32'(bus.collisionCount), 32'h1);
    chk("coinc_edge",  32'(bus.collisionEdge), 32'h6);
    chk("coinc_mask",  32'(bus.collisionMask), 32'h1);

    // Saturation at 255
    bus.drawRequest = 4'b1001; bus.hookHitEdge = 3'd1;
    for (int i = 0; i < 300; i++) step();
    chk("sat_rgb", 32'(bus.RGBOut), 32'hA5);
    bus.drawRequest = 4'b0000;
    sof_step();
    chk("sat_pulse", 32'(bus.collision), 32'h1);
    chk("sat_count", 32'(bus.collisionCount), 32'hFF);
    chk("sat_mask",  32'(bus.collisionMask), 32'h4);
    chk("sat_edge",  32'(bus.collisionEdge), 32'h1);

    // Reset mid-frame
    bus.drawRequest = 4'b0011; bus.hookHitEdge = 3'd3;
    for (int i = 0; i < 5; i++) step();
    chk("mid_rgb_pre", 32'(bus.RGBOut), 32'hA5);
    resetN = 1'b0;
    #1;
    chk("mid_rst_rgb",   32'(bus.RGBOut), 32'h00);
    chk("mid_rst_mask",  32'(bus.collisionMask), 32'h0);
    chk("mid_rst_edge",  32'(bus.collisionEdge), 32'h0);
    chk("mid_rst_count", 32'(bus.collisionCount), 32'h0);
    step();
    chk("mid_rst_rgb_hold", 32'(bus.RGBOut), 32'h00);
    resetN = 1'b1;
    bus.drawRequest = 4'b0000;
    sof_step();
    chk("mid_no_report", 32'(bus.collision), 32'h0);
    chk("mid_count",     32'(bus.collisionCount), 32'h0);
    chk("mid_mask",      32'(bus.collisionMask), 32'h0);
    step();
    chk("mid_no_report_b", 32'(bus.collision), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
